nios_pio_ext: RTL and testbench
===============================

NIOS_PIO_EXT -- requirements
Module: nios_pio_ext

Interface
REQ-001 Parameter WIDTH, default 8: port width in bits, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter RESET_VALUE, default 0: reset value of data_out, WIDTH bits.
REQ-004 Parameter SYNC_STAGES, default 2: depth of the input synchroniser, legal range 2..3.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 in_port  input  WIDTH  asynchronous external inputs.
REQ-013 out_port  output  WIDTH  output data register.
REQ-014 out_en  output  WIDTH  per-bit drive enable, equal to the direction register; 1 = output.
REQ-015 irq  output  1  level interrupt.

Function
REQ-016 in_port SHALL pass through SYNC_STAGES flops to form in_sync; the edge detector compares in_sync with its value one cycle earlier (in_prev).
REQ-017 The register map SHALL be: 0 data, 1 direction, 2 irq_mask, 3 edge_capture, 4 outset, 5 outclear; addresses 6 and 7 read 0 and ignore writes.
REQ-018 A write SHALL occur only when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-019 Writing address 0 SHALL load data_out; writing 1 SHALL load direction; writing 2 SHALL load irq_mask.
REQ-020 Writing address 4 SHALL set data_out bits where writedata=1; writing 5 SHALL clear data_out bits where writedata=1; all other bits are unchanged.
REQ-021 Writing address 3 SHALL clear each edge_capture bit where writedata=1 (write-1-to-clear).
REQ-022 An edge_capture bit SHALL set, one cycle after the qualifying edge appears on in_sync, per EDGE_TYPE; set takes priority over a simultaneous clear of the same bit.
REQ-023 Edge detection SHALL apply to all bits regardless of direction.
REQ-024 readdata SHALL update every clock (independent of chipselect) with the selected register, zero-extended to 32 bits: one-cycle read latency.
REQ-025 A read of address 0 SHALL return (direction & data_out) | (~direction & in_sync).
REQ-026 Reads of addresses 4 and 5 SHALL return 0.
REQ-027 irq SHALL be registered and equal OR(edge_capture & irq_mask) from the previous cycle.
REQ-028 out_port SHALL equal data_out and out_en SHALL equal direction, both driven directly from registers.

Reset
REQ-029 On reset=1 at a clk edge: data_out=RESET_VALUE, direction=0, irq_mask=0, edge_capture=0, readdata=0, irq=0, all synchroniser flops and in_prev=0.
REQ-030 Reset SHALL take priority over any simultaneous write or edge; a mid-operation reset discards pending captures.
REQ-031 The first cycle after reset SHALL NOT register a spurious edge: in_prev tracks in_sync from reset.

Structure
REQ-032 A shared package nios_pio_pkg SHALL hold the address constants (ADDR_DATA through ADDR_OUTCLR) and the EDGE_TYPE encodings.
REQ-033 The synchroniser SHALL be the sub-module nios_pio_sync (parameters WIDTH and SYNC_STAGES); all other logic stays in nios_pio_ext.
REQ-034 The target size is 150-250 RTL lines; no memories and no tristates inside the block.

Verification
REQ-035 Reset, then read address 0 with in_port=0xA5 and direction=0 -> readdata=0x000000A5 on the second read cycle after sync latency; out_port=RESET_VALUE.
REQ-036 Write 0xF0 to address 1 and 0x3C to address 0, with in_port=0x0F -> out_en=0xF0, out_port=0x3C, address 0 reads 0x3F.
REQ-037 data_out=0x00; write 0x81 to address 4, then 0x01 to address 5 -> out_port becomes 0x81, then 0x80.
REQ-038 EDGE_TYPE=0, mask=0x02, bit 1 rises -> edge_capture=0x02 and irq=1 one cycle after capture; write 0x02 to address 3 -> irq=0.
REQ-039 Bit 1 rises on the same cycle that address 3 is written with 0x02 -> edge_capture bit 1 stays 1.
REQ-040 Assert reset with edge_capture=0xFF and irq=1 -> next cycle all registers are at reset values and irq=0.

Source files
------------

// File: rtl/nios_pio_pkg.sv
// Shared constants for the PIO block: Avalon register map and edge-select encodings.
package nios_pio_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/nios_pio_sync.sv
// Multi-flop synchroniser for the asynchronous PIO inputs; clears on reset.
module nios_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] in_sync
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/nios_pio_ext.sv
// Avalon-MM parallel I/O port: data/direction/mask registers, set/clear aliases,
// edge capture with write-1-to-clear, registered read data and level interrupt.
module nios_pio_ext
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev_q, in_prev_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_sel;

  nios_pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .in_async (in_port),
    .in_sync  (in_sync)
  );

  if (WIDTH < 32) begin : g_unused
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[31:WIDTH];
  end

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edges = in_sync & ~in_prev_q;
      EDGE_FALL: edges = ~in_sync & in_prev_q;
      default:   edges = in_sync ^ in_prev_q;
    endcase
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    cap_clr    = '0;
    in_prev_d  = in_sync;
    if (wr) begin
      case (address)
        ADDR_DATA:    data_out_d = wd;
        ADDR_DIR:     dir_d      = wd;
        ADDR_IRQMASK: mask_d     = wd;
        ADDR_EDGECAP: cap_clr    = wd;
        ADDR_OUTSET:  data_out_d = data_out_q | wd;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
        default: ;
      endcase
    end
    // A new edge wins over a clear of the same bit in the same cycle.
    cap_d = (cap_q & ~cap_clr) | edges;
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    rd_sel = '0;
    case (address)
      ADDR_DATA:    rd_sel = (dir_q & data_out_q) | (~dir_q & in_sync);
      ADDR_DIR:     rd_sel = dir_q;
      ADDR_IRQMASK: rd_sel = mask_q;
      ADDR_EDGECAP: rd_sel = cap_q;
      default:      rd_sel = '0;
    endcase
    readdata_d              = '0;
    readdata_d[WIDTH-1:0]   = rd_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      in_prev_q  <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      in_prev_q  <= in_prev_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_out_q;
  assign out_en   = dir_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_nios_pio_ext.sv
// Directed vector table plus randomized traffic checked against a cycle model of the PIO.
module tb_nios_pio_ext;
  localparam int         W  = 8;
  localparam int         ET = 0;
  localparam int         SS = 2;
  localparam logic [7:0] RV = 8'h5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port, out_port, out_en;
  logic        irq;

  int checks = 0;
  int failures = 0;

  nios_pio_ext #(.WIDTH(W), .EDGE_TYPE(ET), .RESET_VALUE(RV), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_en(out_en), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_data, m_dir, m_mask, m_cap, m_prev;
  logic [31:0] m_rd;
  logic        m_irq;
  logic [7:0]  m_hist[$];

  typedef struct {
    bit rst; bit cs; bit wn; bit [2:0] addr; bit [7:0] wd; bit [7:0] inp;
    bit cp; bit [7:0] ep; bit ce; bit [7:0] ee; bit cr; bit [31:0] er; bit ci; bit ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit cs, bit wn, bit [2:0] addr, bit [7:0] wd, bit [7:0] inp,
                              bit cp, bit [7:0] ep, bit ce, bit [7:0] ee,
                              bit cr, bit [31:0] er, bit ci, bit ei);
    vec_t v;
    v.rst = rst; v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd; v.inp = inp;
    v.cp = cp; v.ep = ep; v.ce = ce; v.ee = ee; v.cr = cr; v.er = er; v.ci = ci; v.ei = ei;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the behavioural model, using the inputs in force at the edge.
  task automatic model_step(bit rst, bit cs, bit wn, bit [2:0] addr, bit [7:0] wd, bit [7:0] inp);
    logic [7:0] cur, ev, clr;
    bit wr;
    if (rst) begin
      m_data = RV; m_dir = 0; m_mask = 0; m_cap = 0; m_rd = 0; m_irq = 0; m_prev = 0;
      m_hist = {};
      for (int i = 0; i < SS; i++) m_hist.push_back(8'h00);
    end else begin
      cur = m_hist[SS-1];
      case (addr)
        3'd0: m_rd = {24'h0, (m_dir & m_data) | (~m_dir & cur)};
        3'd1: m_rd = {24'h0, m_dir};
        3'd2: m_rd = {24'h0, m_mask};
        3'd3: m_rd = {24'h0, m_cap};
        default: m_rd = 0;
      endcase
      m_irq = (m_cap & m_mask) != 0;
      if (ET == 0)      ev = cur & ~m_prev;
      else if (ET == 1) ev = ~cur & m_prev;
      else              ev = cur ^ m_prev;
      wr  = cs && !wn;
      clr = (wr && addr == 3'd3) ? wd : 8'h00;
      m_cap = (m_cap & ~clr) | ev;
      if (wr) begin
        case (addr)
          3'd0: m_data = wd;
          3'd1: m_dir = wd;
          3'd2: m_mask = wd;
          3'd4: m_data = m_data | wd;
          3'd5: m_data = m_data & ~wd;
          default: ;
        endcase
      end
      m_prev = cur;
      m_hist.push_front(inp);
      void'(m_hist.pop_back());
    end
  endtask

  task automatic step(bit rst, bit cs, bit wn, bit [2:0] addr, logic [31:0] wd, bit [7:0] inp);
    reset = rst; chipselect = cs; write_n = wn; address = addr; writedata = wd; in_port = inp;
    @(posedge clk);
    #1;
    model_step(rst, cs, wn, addr, wd[7:0], inp);
    chk("model_out_port", {24'h0, out_port}, {24'h0, m_data});
    chk("model_out_en",   {24'h0, out_en},   {24'h0, m_dir});
    chk("model_readdata", readdata, m_rd);
    chk("model_irq",      {31'h0, irq},      {31'h0, m_irq});
  endtask

  initial begin
    // rst cs wn addr wd inp | cp ep | ce ee | cr er | ci ei
    tbl.push_back(mk(1,0,1,0,8'h00,8'hA5, 1,8'h5A, 1,8'h00, 1,32'h0, 1,0));
    tbl.push_back(mk(0,0,1,0,8'h00,8'hA5, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,0,1,0,8'h00,8'hA5, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,0,1,0,8'h00,8'hA5, 1,8'h5A, 0,0, 1,32'hA5, 0,0));
    tbl.push_back(mk(0,1,0,1,8'hF0,8'h0F, 0,0, 1,8'hF0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,8'h3C,8'h0F, 1,8'h3C, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,1,0,8'h00,8'h0F, 1,8'h3C, 1,8'hF0, 1,32'h3F, 0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,8'h0F, 1,8'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,4,8'h81,8'h0F, 1,8'h81, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,5,8'h01,8'h0F, 1,8'h80, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,1,8'h00,8'h0D, 0,0, 1,8'h00, 1,32'hF0, 0,0));
    tbl.push_back(mk(0,1,0,3,8'hFF,8'h0D, 0,0, 0,0, 0,0, 1,0));
    tbl.push_back(mk(0,1,0,2,8'h02,8'h0D, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h0, 1,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h02, 1,1));
    tbl.push_back(mk(0,1,0,3,8'h02,8'h0F, 0,0, 0,0, 1,32'h02, 1,1));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0D, 0,0, 0,0, 1,32'h0, 1,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0D, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h0, 0,0));
    tbl.push_back(mk(0,1,0,3,8'h02,8'h0F, 0,0, 0,0, 1,32'h0, 1,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h02, 1,1));
    tbl.push_back(mk(1,1,0,0,8'hFF,8'h0F, 1,8'h5A, 1,8'h00, 1,32'h0, 1,0));
    tbl.push_back(mk(0,0,1,3,8'h00,8'h0F, 0,0, 0,0, 1,32'h0, 1,0));
    tbl.push_back(mk(0,0,1,2,8'h00,8'h0F, 1,8'h5A, 0,0, 1,32'h0, 0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].cs, tbl[i].wn, tbl[i].addr, {24'hFFFFFF, tbl[i].wd}, tbl[i].inp);
      if (tbl[i].cp) chk($sformatf("vec%0d_out_port", i), {24'h0, out_port}, {24'h0, tbl[i].ep});
      if (tbl[i].ce) chk($sformatf("vec%0d_out_en", i),   {24'h0, out_en},   {24'h0, tbl[i].ee});
      if (tbl[i].cr) chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].er);
      if (tbl[i].ci) chk($sformatf("vec%0d_irq", i),      {31'h0, irq},      {31'h0, tbl[i].ei});
    end

    // Randomized traffic; inputs toggle slowly enough for edges to be captured and cleared.
    begin
      logic [7:0] inp;
      inp = 8'h00;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 2) == 0) inp = 8'($urandom);
        step($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom),
             3'($urandom), $urandom, inp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
